// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory,
// and pairs each returned word with its PC, with stall hold and zero-bubble redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] i_addr,
    input  logic [31:0] mem_instruction,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic [31:0] hold_instr;
    logic        hold_valid;
    logic [31:0] target_pc;

    assign target_pc = redirect_pc & ~32'h3;

    // Redirect target goes straight to memory so its word returns next cycle.
    assign i_addr         = redirect ? target_pc : fetch_pc;
    assign if_valid       = resp_valid;
    assign if_pc          = resp_pc;
    assign if_instruction = hold_valid ? hold_instr : mem_instruction;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            resp_pc    <= 32'h0;
            resp_valid <= 1'b0;
            hold_instr <= 32'h0;
            hold_valid <= 1'b0;
        end else if (redirect) begin
            resp_pc    <= target_pc;
            resp_valid <= 1'b1;
            fetch_pc   <= target_pc + 32'd4;
            hold_valid <= 1'b0;
        end else if (stall) begin
            // Memory output moves on while stalled, so latch the presented word once.
            if (resp_valid && !hold_valid) begin
                hold_instr <= mem_instruction;
                hold_valid <= 1'b1;
            end
        end else begin
            resp_pc    <= fetch_pc;
            resp_valid <= 1'b1;
            fetch_pc   <= fetch_pc + 32'd4;
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected pairs are queued as stimulus is driven
// and popped against the DUT outputs at each falling edge.
module tb_fetch_unit;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc, i_addr, mem_instruction, if_pc, if_instruction;
    logic        if_valid;

    logic        reset2, stall2, redirect2;
    logic [31:0] redirect_pc2, i_addr2, mem_instruction2, if_pc2, if_instruction2;
    logic        if_valid2;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .i_addr(i_addr), .mem_instruction(mem_instruction),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset2), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .i_addr(i_addr2), .mem_instruction(mem_instruction2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_instruction(if_instruction2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 256-word memory, mem[k] = A000_0000 + k, address taken modulo depth
    always @(posedge clk) begin
        mem_instruction  <= 32'hA000_0000 + {24'h0, i_addr[9:2]};
        mem_instruction2 <= 32'hA000_0000 + {24'h0, i_addr2[9:2]};
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        step();
        total++;
        if ({if_valid, if_pc, i_addr, dut.hold_valid} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got valid=%0b pc=%h i_addr=%h hold=%0b, want 0/0/0/0",
                     if_valid, if_pc, i_addr, dut.hold_valid);
        end
        reset = 1'b0;
        #1;
        total++;
        if (if_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_cycle_invalid: got valid=%0b want 0", if_valid);
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        for (int k = 0; k < 3; k++) sb.push_back('{1'b1, 32'(k * 4), 32'hA000_0000 + 32'(k)});
        for (int k = 0; k < 3; k++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({if_valid, if_pc, if_instruction} !== {e.valid, e.pc, e.instr}) begin
                bad++;
                $display("FAIL seq%0d: got %0b/%h/%h want %0b/%h/%h", k,
                         if_valid, if_pc, if_instruction, e.valid, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        // presented pair is 8 / A0000002 on entry
        stall = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back('{1'b1, 32'h8, 32'hA000_0002});
        for (int k = 0; k < 3; k++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({if_valid, if_pc, if_instruction} !== {e.valid, e.pc, e.instr}) begin
                bad++;
                $display("FAIL stall_hold%0d: got %0b/%h/%h want %0b/%h/%h", k,
                         if_valid, if_pc, if_instruction, e.valid, e.pc, e.instr);
            end
        end
        stall = 1'b0;
        sb.push_back('{1'b1, 32'h8, 32'hA000_0002});
        #1;
        e = sb.pop_front();
        total++;
        if ({if_valid, if_pc, if_instruction} !== {e.valid, e.pc, e.instr}) begin
            bad++;
            $display("FAIL stall_release: got %0b/%h/%h want %0b/%h/%h",
                     if_valid, if_pc, if_instruction, e.valid, e.pc, e.instr);
        end
        sb.push_back('{1'b1, 32'hC, 32'hA000_0003});
        sb.push_back('{1'b1, 32'h10, 32'hA000_0004});
        for (int k = 0; k < 2; k++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({if_valid, if_pc, if_instruction} !== {e.valid, e.pc, e.instr}) begin
                bad++;
                $display("FAIL stall_after%0d: got %0b/%h/%h want %0b/%h/%h", k,
                         if_valid, if_pc, if_instruction, e.valid, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        do_reset();
        step();
        step();
        total++;
        if (if_pc !== 32'h4) begin
            bad++;
            $display("FAIL redirect_setup: got pc=%h want 00000004", if_pc);
        end
        redirect = 1'b1; redirect_pc = 32'h40;
        sb.push_back('{1'b1, 32'h40, 32'hA000_0010});
        sb.push_back('{1'b1, 32'h44, 32'hA000_0011});
        for (int k = 0; k < 2; k++) begin
            step();
            redirect = 1'b0;
            e = sb.pop_front();
            total++;
            if ({if_valid, if_pc, if_instruction} !== {e.valid, e.pc, e.instr}) begin
                bad++;
                $display("FAIL redirect%0d: got %0b/%h/%h want %0b/%h/%h", k,
                         if_valid, if_pc, if_instruction, e.valid, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_redirect_stall();
        exp_t e;
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h23;
        step();
        redirect = 1'b0;
        total++;
        if ({if_valid, if_pc, if_instruction, dut.hold_valid} !== {1'b1, 32'h20, 32'hA000_0008, 1'b0}) begin
            bad++;
            $display("FAIL redir_prio: got %0b/%h/%h hold=%0b want 1/00000020/a0000008 hold=0",
                     if_valid, if_pc, if_instruction, dut.hold_valid);
        end
        sb.push_back('{1'b1, 32'h20, 32'hA000_0008});
        sb.push_back('{1'b1, 32'h20, 32'hA000_0008});
        for (int k = 0; k < 2; k++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({if_valid, if_pc, if_instruction} !== {e.valid, e.pc, e.instr}) begin
                bad++;
                $display("FAIL redir_stall_hold%0d: got %0b/%h/%h want %0b/%h/%h", k,
                         if_valid, if_pc, if_instruction, e.valid, e.pc, e.instr);
            end
        end
        stall = 1'b0;
        sb.push_back('{1'b1, 32'h24, 32'hA000_0009});
        step();
        e = sb.pop_front();
        total++;
        if ({if_valid, if_pc, if_instruction} !== {e.valid, e.pc, e.instr}) begin
            bad++;
            $display("FAIL redir_stall_release: got %0b/%h/%h want %0b/%h/%h",
                     if_valid, if_pc, if_instruction, e.valid, e.pc, e.instr);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        sb.push_back('{1'b1, 32'hFFFF_FFF8, 32'hA000_00FE});
        sb.push_back('{1'b1, 32'hFFFF_FFFC, 32'hA000_00FF});
        sb.push_back('{1'b1, 32'h0000_0000, 32'hA000_0000});
        for (int k = 0; k < 3; k++) begin
            step();
            e = sb.pop_front();
            total++;
            if ({if_valid2, if_pc2, if_instruction2} !== {e.valid, e.pc, e.instr}) begin
                bad++;
                $display("FAIL wrap%0d: got %0b/%h/%h want %0b/%h/%h", k,
                         if_valid2, if_pc2, if_instruction2, e.valid, e.pc, e.instr);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        step();
        total++;
        if ({dut.hold_valid, if_valid} !== 2'b11) begin
            bad++;
            $display("FAIL pre_reset_stall: got hold=%0b valid=%0b want 1/1", dut.hold_valid, if_valid);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({if_valid, if_pc, dut.hold_valid, i_addr} !== {1'b0, 32'h0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL async_reset: got valid=%0b pc=%h hold=%0b i_addr=%h want 0/0/0/0",
                     if_valid, if_pc, dut.hold_valid, i_addr);
        end
        @(negedge clk);
        stall = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of `instruction_mem`. It owns the program counter and drives `i_addr` to the synchronous-read instruction memory. It pairs the memory's 1-cycle-late `instruction` output with the PC that produced it and presents a valid PC/instruction pair to decode. It also handles back-pressure from decode (stall) and control-flow redirects from a later stage, with zero-bubble redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Must be word-aligned.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high. Dominates every other input.
- `stall` input 1: decode cannot accept the current pair; hold the presented output.
- `redirect` input 1: taken branch/jump. Priority over `stall`.
- `redirect_pc` input 32: redirect target. Bits [1:0] are ignored and treated as 0.
- `i_addr` output 32: fetch address to `instruction_mem`. Sampled by memory at the rising edge.
- `mem_instruction` input 32: `instruction` output of `instruction_mem`. Holds the word for the address sampled at the previous edge.
- `if_valid` output 1: `if_pc`/`if_instruction` hold a real fetched pair.
- `if_pc` output 32: PC of the presented instruction.
- `if_instruction` output 32: presented instruction word.

## Operation
- State registers:
  - `fetch_pc`: next sequential address.
  - `resp_pc`, `resp_valid`: the address the memory is currently returning.
  - `hold_instr`, `hold_valid`: instruction captured while stalled.
- `i_addr` is combinational: `{redirect_pc[31:2],2'b00}` when `redirect`, else `fetch_pc`.
- Outputs:
  - `if_valid = resp_valid`.
  - `if_pc = resp_pc`.
  - `if_instruction = hold_valid ? hold_instr : mem_instruction`.
- Per-edge update, highest priority first:
  - **redirect**:
    - `resp_pc <= aligned redirect_pc`, `resp_valid <= 1`.
    - `fetch_pc <= aligned redirect_pc + 4`.
    - `hold_valid <= 0`.
    - The pair presented this cycle is discarded.
  - **stall**:
    - `fetch_pc`, `resp_pc`, `resp_valid` hold.
    - If `resp_valid && !hold_valid`: `hold_instr <= mem_instruction`, `hold_valid <= 1`. Otherwise the hold registers keep their value.
  - **advance**:
    - `resp_pc <= fetch_pc`, `resp_valid <= 1`.
    - `fetch_pc <= fetch_pc + 4`.
    - `hold_valid <= 0`.
- PC arithmetic: 32-bit, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Stall with `resp_valid = 0` (first cycle after reset): state holds and no capture occurs.
- Stall release: on the release cycle `hold_instr` is still presented. At that edge the memory samples the held `fetch_pc`, so the next `mem_instruction` matches the new `resp_pc`. No instruction is lost or duplicated.
- Redirect and stall in the same cycle: the redirect is taken and the stall is ignored for that edge.

## Timing
- Reset values, applied immediately on `reset` assertion:
  - `fetch_pc = RESET_PC`.
  - `resp_pc = 0`, `resp_valid = 0`.
  - `hold_instr = 0`, `hold_valid = 0`.
  - Therefore `i_addr = RESET_PC` (if no redirect), `if_valid = 0`, `if_pc = 0`.
- First edge after `reset` deasserts: memory samples `RESET_PC`. The next cycle shows `if_valid = 1`, `if_pc = RESET_PC`, `if_instruction = mem[RESET_PC/4]`.
- Fetch latency: 1 cycle from the `i_addr` edge to the pair on the `if_*` outputs. Throughput is 1 instruction per cycle when unstalled.
- Redirect latency: 1 cycle. The target pair is valid in the cycle after `redirect`, with no bubble.
- While `stall` is high, the `if_*` outputs are stable from the first stalled cycle until the cycle after release.
- Reset mid-stall or mid-redirect: all state clears asynchronously and `if_valid` drops in the same cycle.

## Test plan
Memory model: `mem[k] = 32'hA000_0000 + k`.

- **Reset/sequential**: `RESET_PC = 0`, release reset, no stall.
  - `if_valid` is 0 in the first cycle.
  - Then `(if_pc, if_instruction)` = (0, A0000000), (4, A0000001), (8, A0000002), one pair per cycle.
- **Stall hold**: assert `stall` for 3 cycles while `if_pc = 8`.
  - `if_pc = 8` and `if_instruction = A0000002` are stable through all stalled cycles plus the release cycle.
  - Then 12 / A0000003 follows with no gap or duplicate.
- **Redirect**: pulse `redirect` with `redirect_pc = 32'h40` while `if_pc = 4`.
  - Next cycle: `if_pc = 0x40`, `if_instruction = A0000010`.
  - Then `0x44` / A0000011.
- **Redirect priority/alignment**: assert `redirect` and `stall` together with `redirect_pc = 32'h23`.
  - Next cycle: `if_pc = 0x20`, `if_instruction = A0000008`, `hold_valid` cleared.
  - Keep `stall` high: `if_pc = 0x20` is held.
- **Wrap-around**: `RESET_PC = 32'hFFFF_FFF8` (memory model indexed modulo depth).
  - `if_pc` sequence is FFFFFFF8, FFFFFFFC, 00000000.
- **Async reset mid-stall**: assert `reset` between clock edges during a stall.
  - `if_valid`, `if_pc`, and `hold_valid` go to 0 immediately.
  - `i_addr = RESET_PC` before the next edge.
